// File: rtl/watch_pkg.sv
// Shared watch constants: button bit indices, one-hot button codes and the
// press-pulse priority arbiter used by the front-panel conditioner.
package watch_pkg;

  localparam int unsigned NUM_BTN = 5;

  typedef logic [NUM_BTN-1:0] btn_t;

  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 3;
  localparam int unsigned BTN_CENTER = 2;
  localparam int unsigned BTN_LEFT   = 1;
  localparam int unsigned BTN_RIGHT  = 0;

  localparam btn_t UP     = 5'b10000;
  localparam btn_t DOWN   = 5'b01000;
  localparam btn_t CENTER = 5'b00100;
  localparam btn_t LEFT   = 5'b00010;
  localparam btn_t RIGHT  = 5'b00001;

  localparam btn_t DEFAULT_REPEAT_MASK = UP | DOWN;

  // CENTER outranks UP so a confirm press is never masked by a held UP/DOWN.
  function automatic btn_t arbitrate(btn_t rp);
    btn_t grant;
    grant = '0;
    if (rp[BTN_CENTER])     grant = CENTER;
    else if (rp[BTN_UP])    grant = UP;
    else if (rp[BTN_DOWN])  grant = DOWN;
    else if (rp[BTN_LEFT])  grant = LEFT;
    else if (rp[BTN_RIGHT]) grant = RIGHT;
    return grant;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Front-panel button bundle: raw levels in, debounced levels and pulses out.
interface button_conditioner_if
  import watch_pkg::*;
#(
  parameter int unsigned N_BTN = NUM_BTN
);

  logic [N_BTN-1:0] BTN_RAW;
  logic [N_BTN-1:0] BTN_LEVEL;
  logic [N_BTN-1:0] BUTTONS;

  modport master (
    output BTN_RAW,
    input  BTN_LEVEL,
    input  BUTTONS
  );

  modport slave (
    input  BTN_RAW,
    output BTN_LEVEL,
    output BUTTONS
  );

endinterface

// File: rtl/button_debounce.sv
// One button: two-flop synchronizer, debounce counter, press edge detect and
// optional auto-repeat. `pulse` is the press/repeat event for the coming edge.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned REPEAT_DELAY    = 500,
  parameter int unsigned REPEAT_RATE     = 100,
  parameter bit          REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  localparam logic [CW-1:0] CntLast   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DelayLast = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RateLast  = RW'(REPEAT_RATE - 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          first_q, first_d;
  logic          toggle, rise, fall, rep_fire;

  always_comb begin
    toggle   = (s2_q != level_q) && (cnt_q == CntLast);
    rise     = toggle && !level_q;
    fall     = toggle && level_q;
    level_d  = level_q ^ toggle;
    cnt_d    = ((s2_q == level_q) || toggle) ? '0 : cnt_q + 1'b1;
    rcnt_d   = rcnt_q;
    first_d  = first_q;
    rep_fire = 1'b0;
    if (REPEAT_EN) begin
      if (rise) begin
        rcnt_d  = '0;
        first_d = 1'b1;
      end else if (level_q && !fall) begin
        if (rcnt_q == (first_q ? DelayLast : RateLast)) begin
          rep_fire = 1'b1;
          rcnt_d   = '0;
          first_d  = 1'b0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end else begin
        // Released, or releasing on this edge: no repeat on release.
        rcnt_d  = '0;
        first_d = 1'b0;
      end
    end
    pulse = rise | rep_fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      first_q <= 1'b0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      first_q <= first_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/button_conditioner.sv
// Front-panel conditioner: one debouncer per button, then a priority arbiter
// so BUTTONS carries at most one registered one-cycle pulse.
module button_conditioner
  import watch_pkg::*;
#(
  parameter int unsigned N_BTN           = NUM_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned REPEAT_DELAY    = 500,
  parameter int unsigned REPEAT_RATE     = 100,
  parameter btn_t        REPEAT_MASK     = DEFAULT_REPEAT_MASK
) (
  input  logic                 CLK,
  input  logic                 RESET,
  button_conditioner_if.slave  bus
);

  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] rp;
  btn_t             buttons_d, buttons_q;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_debounce (
      .clk   (CLK),
      .rst   (RESET),
      .raw   (bus.BTN_RAW[i]),
      .level (level[i]),
      .pulse (rp[i])
    );
  end

  // Lower-priority pulses in the same cycle are dropped, not queued.
  always_comb begin
    buttons_d = arbitrate(rp);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      buttons_q <= '0;
    end else begin
      buttons_q <= buttons_d;
    end
  end

  assign bus.BTN_LEVEL = level;
  assign bus.BUTTONS   = buttons_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: table of single/multi presses, hand-written
// bounce/repeat/reset sequences and a random run against a reference model.
module tb_button_conditioner;
  import watch_pkg::*;

  localparam int D  = 20;
  localparam int RD = 500;
  localparam int RR = 100;

  logic CLK = 1'b0;
  logic RESET;

  button_conditioner_if #(.N_BTN(NUM_BTN)) bus ();

  button_conditioner #(
    .N_BTN           (NUM_BTN),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR),
    .REPEAT_MASK     (DEFAULT_REPEAT_MASK)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state
  bit [4:0] m_s1, m_s2, m_prev, m_level, m_buttons;
  int       m_run[5];
  int       m_press[5];
  bit [4:0] rep_mask;

  int       pq_cyc[$];
  bit [4:0] pq_val[$];

  typedef struct {
    logic [4:0] raw;
    int         hold;
    logic [4:0] exp_pulse;
  } vec_t;
  vec_t tbl[8];

  task automatic check_vec(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic bit [4:0] pick(input bit [4:0] rp);
    int order[5];
    bit [4:0] g;
    order = '{BTN_CENTER, BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT};
    g = '0;
    for (int p = 0; p < 5; p++) begin
      if (g == 0 && rp[order[p]]) g[order[p]] = 1'b1;
    end
    return g;
  endfunction

  // Level accepted once the synchronized value has been steady and different
  // for D edges; repeats at fixed offsets from each button's own press edge.
  task automatic model_edge(input bit rst, input bit [4:0] raw);
    bit [4:0] rp;
    bit       seen, nl;
    int       age;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_prev = '0; m_level = '0; m_buttons = '0;
      for (int i = 0; i < 5; i++) m_run[i] = 0;
      return;
    end
    rp = '0;
    for (int i = 0; i < 5; i++) begin
      seen = m_s2[i];
      m_run[i] = (seen == m_prev[i]) ? m_run[i] + 1 : 1;
      m_prev[i] = seen;
      nl = m_level[i];
      if (seen != m_level[i] && m_run[i] >= D) nl = seen;
      if (nl && !m_level[i]) begin
        rp[i] = 1'b1;
        m_press[i] = cyc;
      end else if (nl && m_level[i] && rep_mask[i]) begin
        age = cyc - m_press[i];
        if (age == RD || (age > RD && (age - RD) % RR == 0)) rp[i] = 1'b1;
      end
      m_level[i] = nl;
    end
    m_s2 = m_s1;
    m_s1 = raw;
    m_buttons = pick(rp);
  endtask

  task automatic step(input bit rst, input bit [4:0] raw);
    RESET = rst;
    bus.BTN_RAW = raw;
    @(posedge CLK);
    cyc++;
    model_edge(rst, raw);
    #1;
    check_vec("model_level", bus.BTN_LEVEL, m_level);
    check_vec("model_buttons", bus.BUTTONS, m_buttons);
    if (bus.BUTTONS != 0) begin
      pq_cyc.push_back(cyc);
      pq_val.push_back(bus.BUTTONS);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 5'b0);
    pq_cyc.delete();
    pq_val.delete();
  endtask

  initial begin
    int k, k2, p, fall;
    bit [4:0] cur, glitch;
    rep_mask = DEFAULT_REPEAT_MASK;
    tbl[0] = '{raw: LEFT,           hold: 200, exp_pulse: LEFT};
    tbl[1] = '{raw: RIGHT,          hold: 60,  exp_pulse: RIGHT};
    tbl[2] = '{raw: CENTER,         hold: 60,  exp_pulse: CENTER};
    tbl[3] = '{raw: UP,             hold: 60,  exp_pulse: UP};
    tbl[4] = '{raw: CENTER | RIGHT, hold: 50,  exp_pulse: CENTER};
    tbl[5] = '{raw: UP | DOWN,      hold: 60,  exp_pulse: UP};
    tbl[6] = '{raw: LEFT | RIGHT,   hold: 60,  exp_pulse: LEFT};
    tbl[7] = '{raw: 5'b11111,       hold: 60,  exp_pulse: CENTER};

    // Reset and idle
    do_reset(3);
    check_vec("reset_level", bus.BTN_LEVEL, 5'b0);
    check_vec("reset_buttons", bus.BUTTONS, 5'b0);
    repeat (100) step(1'b0, 5'b0);
    check_int("idle_pulses", pq_cyc.size(), 0);

    // Table of clean presses and simultaneous presses
    for (int t = 0; t < 8; t++) begin
      do_reset(2);
      repeat (5) step(1'b0, 5'b0);
      k = cyc + 1;
      repeat (tbl[t].hold) step(1'b0, tbl[t].raw);
      check_int("tbl_npulse", pq_cyc.size(), 1);
      if (pq_cyc.size() > 0) begin
        check_int("tbl_delay", pq_cyc[0] - k, 21);
        check_vec("tbl_pulse", pq_val[0], tbl[t].exp_pulse);
      end
      check_vec("tbl_level", bus.BTN_LEVEL, tbl[t].raw);
      k2 = cyc + 1;
      fall = -1;
      for (int j = 0; j < 30; j++) begin
        step(1'b0, 5'b0);
        if (fall < 0 && bus.BTN_LEVEL == 0) fall = cyc - k2;
      end
      check_int("tbl_release", fall, 21);
      check_int("tbl_npulse_rel", pq_cyc.size(), 1);
    end

    // Bounce rejection on UP
    do_reset(2);
    for (int i = 0; i < 60; i++) step(1'b0, ((i / 5) % 2 == 0) ? UP : 5'b0);
    check_int("bounce_quiet", pq_cyc.size(), 0);
    k = cyc + 1;
    repeat (40) step(1'b0, UP);
    check_int("bounce_npulse", pq_cyc.size(), 1);
    if (pq_cyc.size() > 0) check_int("bounce_delay", pq_cyc[0] - k, 21);

    // Auto-repeat on DOWN; release lands exactly on a repeat slot
    do_reset(2);
    k = cyc + 1;
    repeat (1000) step(1'b0, DOWN);
    repeat (200) step(1'b0, 5'b0);
    check_int("repeat_npulse", pq_cyc.size(), 6);
    if (pq_cyc.size() == 6) begin
      p = pq_cyc[0];
      check_int("repeat_p", p - k, 21);
      check_int("repeat_1", pq_cyc[1] - p, 500);
      check_int("repeat_2", pq_cyc[2] - p, 600);
      check_int("repeat_5", pq_cyc[5] - p, 900);
      check_vec("repeat_val", pq_val[3], DOWN);
    end

    // Reset in the middle of an UP hold
    do_reset(2);
    k = cyc + 1;
    for (int j = 0; j < 60 && pq_cyc.size() == 0; j++) step(1'b0, UP);
    check_int("rst_mid_npulse", pq_cyc.size(), 1);
    p = (pq_cyc.size() > 0) ? pq_cyc[0] : cyc;
    check_int("rst_mid_p", p - k, 21);
    while (cyc < p + 299) step(1'b0, UP);
    step(1'b1, UP);
    check_vec("rst_mid_level", bus.BTN_LEVEL, 5'b0);
    check_vec("rst_mid_buttons", bus.BUTTONS, 5'b0);
    pq_cyc.delete();
    pq_val.delete();
    k2 = cyc + 1;
    repeat (560) step(1'b0, UP);
    check_int("rst_mid_npulse2", pq_cyc.size(), 2);
    if (pq_cyc.size() == 2) begin
      check_int("rst_mid_newp", pq_cyc[0] - k2, 21);
      check_int("rst_mid_rep", pq_cyc[1] - pq_cyc[0], 500);
    end

    // Random run with bounces and occasional reset
    do_reset(2);
    cur = '0;
    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < 5; b++) begin
        if ($urandom_range(0, (b >= 3) ? 399 : 99) == 0) cur[b] = ~cur[b];
      end
      glitch = '0;
      if ($urandom_range(0, 49) == 0) glitch[$urandom_range(0, 4)] = 1'b1;
      step($urandom_range(0, 999) == 0, cur ^ glitch);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
